trees_stream_ctrl: RTL and testbench

TREES_STREAM_CTRL -- requirements
Module: trees_stream_ctrl

---
 rtl/trees_pkg.sv | 25 ++
 rtl/trees_stream_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_trees_stream_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trees_pkg.sv
// Shared definitions for the tree-ensemble stream controller and its ping-pong neighbour.
// Holds the parameter defaults, the controller state encoding and the packing helper.
package trees_pkg;

    localparam int N_TREES_DEF          = 16;
    localparam int N_NODE_AND_LEAFS_DEF = 256;
    localparam int N_FEATURE_DEF        = 32;
    localparam int MAX_BURST_DEF        = 5000;
    localparam int PRED_PER_WORD        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_TREES,
        ST_LD_FEAT,
        ST_START,
        ST_RUN,
        ST_READ
    } tsc_state_t;

    // Output words needed to carry one 8-bit prediction per sample.
    function automatic int pred_words(input int burst);
        return (burst + PRED_PER_WORD - 1) / PRED_PER_WORD;
    endfunction

endpackage

// File: rtl/trees_stream_ctrl.sv
// Job controller: loads trees and features from one input stream into the engine,
// starts it, then streams packed predictions back out.
module trees_stream_ctrl
    import trees_pkg::*;
#(
    parameter int N_TREES          = N_TREES_DEF,
    parameter int N_NODE_AND_LEAFS = N_NODE_AND_LEAFS_DEF,
    parameter int N_FEATURE        = N_FEATURE_DEF,
    parameter int MAX_BURST        = MAX_BURST_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic                                   cfg_trees,
    input  logic [$clog2(MAX_BURST)-1:0]           cfg_burst_len,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [63:0]                            in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [63:0]                            out_data,
    output logic                                   load_trees,
    output logic [$clog2(N_NODE_AND_LEAFS)-1:0]    n_node,
    output logic [$clog2(N_TREES)-1:0]             n_tree,
    output logic [63:0]                            tree_nodes,
    output logic                                   load_features,
    output logic [$clog2(MAX_BURST*N_FEATURE)-1:0] feature_addr,
    output logic [63:0]                            features2,
    output logic [$clog2(MAX_BURST)-1:0]           burst_len,
    output logic                                   start,
    input  logic                                   done,
    input  logic [63:0]                            prediction,
    output logic [$clog2(MAX_BURST)-1:0]           prediction_addr,
    output logic                                   busy,
    output logic                                   job_done,
    output logic                                   cfg_err
);

    localparam int NODE_W  = $clog2(N_NODE_AND_LEAFS);
    localparam int TREE_W  = $clog2(N_TREES);
    localparam int BURST_W = $clog2(MAX_BURST);
    localparam int FADDR_W = $clog2(MAX_BURST * N_FEATURE);
    localparam int TCNT_W  = $clog2(N_TREES + 1);
    localparam int FCNT_W  = $clog2(MAX_BURST * N_FEATURE / 2 + 1);
    localparam int RCNT_W  = $clog2(pred_words(MAX_BURST) + 1);

    localparam logic [BURST_W-1:0] MAX_B     = BURST_W'(MAX_BURST);
    localparam logic [NODE_W-1:0]  NODE_LAST = NODE_W'(N_NODE_AND_LEAFS - 1);
    localparam logic [TCNT_W-1:0]  TREE_LAST = TCNT_W'(N_TREES - 1);

    tsc_state_t          r_state, w_state_nxt;
    logic [BURST_W-1:0]  r_burst_len;
    logic [NODE_W-1:0]   r_node_cnt;
    logic [TCNT_W-1:0]   r_tree_cnt;
    logic [FCNT_W-1:0]   r_feat_cnt;
    logic [RCNT_W-1:0]   r_rd_cnt;
    logic                r_load_trees, r_load_features, r_job_done, r_cfg_err;
    logic [NODE_W-1:0]   r_n_node;
    logic [TREE_W-1:0]   r_n_tree;
    logic [63:0]         r_tree_nodes, r_features2;
    logic [FADDR_W-1:0]  r_feature_addr;

    logic                w_beat, w_cfg_bad, w_tree_last, w_feat_last, w_rd_last;
    logic [FCNT_W-1:0]   w_feat_total;
    logic [RCNT_W-1:0]   w_rd_total;

    assign w_feat_total = FCNT_W'(int'(r_burst_len) * (N_FEATURE / 2));
    assign w_rd_total   = RCNT_W'(pred_words(int'(r_burst_len)));

    assign w_beat      = in_valid & in_ready;
    assign w_cfg_bad   = cfg_burst_len > MAX_B;
    assign w_tree_last = (r_node_cnt == NODE_LAST) && (r_tree_cnt == TREE_LAST);
    assign w_feat_last = (r_feat_cnt == w_feat_total - 1'b1);
    assign w_rd_last   = (r_rd_cnt == w_rd_total - 1'b1);

    // State-derived strobes stay combinational so an async reset clears them at once.
    assign cfg_ready       = (r_state == ST_IDLE);
    assign busy            = (r_state != ST_IDLE);
    assign in_ready        = (r_state == ST_LD_TREES) || (r_state == ST_LD_FEAT);
    assign start           = (r_state == ST_START);
    assign out_valid       = (r_state == ST_READ);
    assign out_data        = out_valid ? prediction : 64'd0;
    assign prediction_addr = BURST_W'(r_rd_cnt);

    assign load_trees    = r_load_trees;
    assign n_node        = r_n_node;
    assign n_tree        = r_n_tree;
    assign tree_nodes    = r_tree_nodes;
    assign load_features = r_load_features;
    assign feature_addr  = r_feature_addr;
    assign features2     = r_features2;
    assign burst_len     = r_burst_len;
    assign job_done      = r_job_done;
    assign cfg_err       = r_cfg_err;

    // NOTE: state register uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid && !w_cfg_bad) begin
                    if (cfg_trees)               w_state_nxt = ST_LD_TREES;
                    else if (cfg_burst_len != 0) w_state_nxt = ST_LD_FEAT;
                end
            end
            ST_LD_TREES: begin
                if (w_beat && w_tree_last)
                    w_state_nxt = (r_burst_len == 0) ? ST_IDLE : ST_LD_FEAT;
            end
            ST_LD_FEAT:  if (w_beat && w_feat_last) w_state_nxt = ST_START;
            ST_START:    w_state_nxt = ST_RUN;
            ST_RUN:      if (done) w_state_nxt = ST_READ;
            ST_READ:     if (out_ready && w_rd_last) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: only control flops and captured outputs exist here; there is no memory needing reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_len     <= '0;
            r_node_cnt      <= '0;
            r_tree_cnt      <= '0;
            r_feat_cnt      <= '0;
            r_rd_cnt        <= '0;
            r_load_trees    <= 1'b0;
            r_load_features <= 1'b0;
            r_job_done      <= 1'b0;
            r_cfg_err       <= 1'b0;
            r_n_node        <= '0;
            r_n_tree        <= '0;
            r_tree_nodes    <= '0;
            r_features2     <= '0;
            r_feature_addr  <= '0;
        end else begin
            r_load_trees    <= 1'b0;
            r_load_features <= 1'b0;
            r_job_done      <= 1'b0;
            r_cfg_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_burst_len <= cfg_burst_len;
                            r_node_cnt  <= '0;
                            r_tree_cnt  <= '0;
                            r_feat_cnt  <= '0;
                            r_rd_cnt    <= '0;
                            // An empty job with no tree reload finishes without leaving IDLE.
                            if (!cfg_trees && cfg_burst_len == 0) r_job_done <= 1'b1;
                        end
                    end
                end
                ST_LD_TREES: begin
                    if (w_beat) begin
                        r_load_trees <= 1'b1;
                        r_tree_nodes <= in_data;
                        r_n_node     <= r_node_cnt;
                        r_n_tree     <= r_tree_cnt[TREE_W-1:0];
                        if (r_node_cnt == NODE_LAST) begin
                            r_node_cnt <= '0;
                            r_tree_cnt <= r_tree_cnt + 1'b1;
                        end else begin
                            r_node_cnt <= r_node_cnt + 1'b1;
                        end
                        if (w_tree_last && r_burst_len == 0) r_job_done <= 1'b1;
                    end
                end
                ST_LD_FEAT: begin
                    if (w_beat) begin
                        r_load_features <= 1'b1;
                        r_features2     <= in_data;
                        r_feature_addr  <= FADDR_W'(r_feat_cnt);
                        r_feat_cnt      <= r_feat_cnt + 1'b1;
                    end
                end
                ST_READ: begin
                    if (out_ready) begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                        if (w_rd_last) r_job_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trees_stream_ctrl.sv
// Directed bench for trees_stream_ctrl: queued expectations for tree, feature and
// prediction beats, plus per-job pulse counts and reset-value checks.
module tb_trees_stream_ctrl;
    import trees_pkg::*;

    localparam int NT  = 16;
    localparam int NN  = 256;
    localparam int NF  = 32;
    localparam int MB  = 5000;
    localparam int BW  = $clog2(MB);
    localparam int FAW = $clog2(MB * NF);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_valid, cfg_ready, cfg_trees;
    logic [BW-1:0]   cfg_burst_len;
    logic            in_valid, in_ready;
    logic [63:0]     in_data;
    logic            out_valid, out_ready;
    logic [63:0]     out_data;
    logic            load_trees;
    logic [7:0]      n_node;
    logic [3:0]      n_tree;
    logic [63:0]     tree_nodes;
    logic            load_features;
    logic [FAW-1:0]  feature_addr;
    logic [63:0]     features2;
    logic [BW-1:0]   burst_len;
    logic            start, done;
    logic [63:0]     prediction;
    logic [BW-1:0]   prediction_addr;
    logic            busy, job_done, cfg_err;

    always #5 clk = ~clk;

    trees_stream_ctrl #(
        .N_TREES(NT), .N_NODE_AND_LEAFS(NN), .N_FEATURE(NF), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_trees(cfg_trees),
        .cfg_burst_len(cfg_burst_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .load_trees(load_trees), .n_node(n_node), .n_tree(n_tree), .tree_nodes(tree_nodes),
        .load_features(load_features), .feature_addr(feature_addr), .features2(features2),
        .burst_len(burst_len),
        .start(start), .done(done), .prediction(prediction), .prediction_addr(prediction_addr),
        .busy(busy), .job_done(job_done), .cfg_err(cfg_err)
    );

    int checks   = 0;
    int failures = 0;
    int job_id   = 0;
    int exp_blen = 0;

    // Prediction memory model: a distinct word per (job, address).
    function automatic logic [63:0] pred_word(input int j, input int a);
        return {16'(j), 16'(a), 32'(a * 32'h9E37_79B1) ^ 32'(j)};
    endfunction

    assign prediction = pred_word(job_id, int'(prediction_addr));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        int          addr;
    } beat_t;

    beat_t       tree_q[$];
    beat_t       feat_q[$];
    logic [63:0] out_q[$];

    int lt_cnt = 0, lf_cnt = 0, st_cnt = 0, jd_cnt = 0, ce_cnt = 0, ow_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [63:0]   prev_data  = '0;
    logic [BW-1:0] prev_addr  = '0;

    always @(negedge clk) begin
        beat_t       b;
        logic [63:0] w;
        if (rst_n) begin
            if (load_trees) begin
                lt_cnt <= lt_cnt + 1;
                if (tree_q.size() > 0) begin
                    b = tree_q.pop_front();
                    check("tree_nodes", tree_nodes, b.data);
                    check("tree_addr", 64'({n_tree, n_node}), 64'(b.addr));
                end
            end
            if (load_features) begin
                lf_cnt <= lf_cnt + 1;
                if (feat_q.size() > 0) begin
                    b = feat_q.pop_front();
                    check("features2", features2, b.data);
                    check("feature_addr", 64'(feature_addr), 64'(b.addr));
                end
            end
            if (start) begin
                st_cnt <= st_cnt + 1;
                check("burst_len_at_start", 64'(burst_len), 64'(exp_blen));
            end
            if (job_done) jd_cnt <= jd_cnt + 1;
            if (cfg_err)  ce_cnt <= ce_cnt + 1;
            if (out_valid) begin
                if (prev_stall) begin
                    check("out_hold_data", out_data, prev_data);
                    check("out_hold_addr", 64'(prediction_addr), 64'(prev_addr));
                end
                if (out_ready) begin
                    ow_cnt <= ow_cnt + 1;
                    if (out_q.size() > 0) begin
                        w = out_q.pop_front();
                        check("out_data", out_data, w);
                    end
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            prev_addr  <= prediction_addr;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic check_reset_vals();
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_load_trees", load_trees, 0);
        check("rst_load_features", load_features, 0);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_job_done", job_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_node_tree", 64'({n_tree, n_node}), 0);
        check("rst_tree_nodes", tree_nodes, 0);
        check("rst_feature_addr", 64'(feature_addr), 0);
        check("rst_features2", features2, 0);
        check("rst_burst_len", 64'(burst_len), 0);
        check("rst_prediction_addr", 64'(prediction_addr), 0);
        check("rst_out_data", out_data, 0);
    endtask

    // One complete job; abort_at > 0 applies reset after that feature/tree beat index.
    task automatic run_job(input bit trees, input int blen, input bit gaps, input bit stall,
                           input bit noise, input int abort_at);
        int nt, nf, nw, lt0, lf0, st0, jd0, ce0, ow0, cyc;
        bit ok;
        nt  = trees ? NT * NN : 0;
        nf  = blen * (NF / 2);
        nw  = (blen + 7) >> 3;
        lt0 = lt_cnt; lf0 = lf_cnt; st0 = st_cnt; jd0 = jd_cnt; ce0 = ce_cnt; ow0 = ow_cnt;
        job_id++;
        exp_blen = blen;
        for (int k = 0; k < nw; k++) out_q.push_back(pred_word(job_id, k));

        cfg_valid = 1'b1; cfg_trees = trees; cfg_burst_len = BW'(blen);
        @(negedge clk);
        check("cfg_ready_idle", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (noise) begin
            cfg_valid = 1'b1; cfg_trees = 1'b1; cfg_burst_len = BW'(MB + 1);
        end

        for (int i = 0; i < nt + nf; i++) begin
            if (gaps && $urandom_range(2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            if (i < nt) tree_q.push_back('{in_data, i});
            else        feat_q.push_back('{in_data, i - nt});
            cyc = 0;
            do begin
                @(negedge clk); ok = in_ready;
                @(posedge clk); #1; cyc++;
            end while (!ok && cyc < 100);
            if (!ok) begin
                check("in_ready_timeout", in_ready, 1);
                break;
            end
            if (i == 0) begin
                check("busy_in_job", busy, 1);
                check("cfg_ready_in_job", cfg_ready, 0);
            end
            if (abort_at > 0 && i == abort_at) begin
                #2; rst_n = 1'b0; in_valid = 1'b0; cfg_valid = 1'b0; #1;
                check_reset_vals();
                tree_q.delete(); feat_q.delete(); out_q.delete();
                repeat (3) @(posedge clk); #1;
                rst_n = 1'b1;
                lf0 = lf_cnt; st0 = st_cnt;
                repeat (6) @(posedge clk); #1;
                check("no_beat_after_reset", 64'(lf_cnt - lf0), 0);
                check("no_start_after_reset", 64'(st_cnt - st0), 0);
                check("idle_after_reset", cfg_ready, 1);
                return;
            end
        end
        in_valid  = 1'b0;
        cfg_valid = 1'b0;

        if (blen == 0) begin
            cyc = 0;
            while (jd_cnt == jd0 && cyc < (trees ? 20 : 2)) begin
                @(posedge clk); cyc++;
            end
            #1;
            check("job_done_empty_job", 64'(jd_cnt - jd0), 1);
        end else begin
            cyc = 0;
            while (st_cnt == st0 && cyc < 50) begin
                @(posedge clk); cyc++;
            end
            #1;
            check("start_seen", 64'(st_cnt - st0), 1);
            repeat (3) @(posedge clk); #1;
            check("wait_for_done", out_valid, 0);
            if (stall) out_ready = 1'b0;
            done = 1'b1;
            @(posedge clk); #1;
            done = 1'b0;
            cyc = 0;
            while (!out_valid && cyc < 10) begin
                @(posedge clk); #1; cyc++;
            end
            check("out_valid_seen", out_valid, 1);
            if (stall) begin
                repeat (10) @(posedge clk); #1;
                check("stall_no_word", 64'(ow_cnt - ow0), 0);
            end
            cyc = 0;
            while (jd_cnt == jd0 && cyc < 500) begin
                out_ready = gaps ? ($urandom_range(1) == 1) : 1'b1;
                @(posedge clk); #1; cyc++;
            end
            check("out_valid_after_last", out_valid, 0);
            out_ready = 1'b1;
        end

        repeat (2) @(posedge clk); #1;
        check("load_trees_count", 64'(lt_cnt - lt0), 64'(nt));
        check("load_features_count", 64'(lf_cnt - lf0), 64'(nf));
        check("start_count", 64'(st_cnt - st0), (blen > 0) ? 64'd1 : 64'd0);
        check("job_done_count", 64'(jd_cnt - jd0), 1);
        check("out_word_count", 64'(ow_cnt - ow0), 64'(nw));
        check("cfg_err_count", 64'(ce_cnt - ce0), 0);
        check("scoreboard_left", 64'(tree_q.size() + feat_q.size() + out_q.size()), 0);
    endtask

    int lt_s, lf_s, st_s, ce_s;

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_trees = 1'b0; cfg_burst_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; done = 1'b0;
        #1;
        check_reset_vals();
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        check("done_in_idle_ignored", busy, 0);

        run_job(1'b1, 1,  1'b0, 1'b0, 1'b0, 0);
        run_job(1'b0, 9,  1'b0, 1'b0, 1'b1, 0);

        lt_s = lt_cnt; lf_s = lf_cnt; st_s = st_cnt; ce_s = ce_cnt;
        cfg_valid = 1'b1; cfg_trees = 1'b1; cfg_burst_len = BW'(MB + 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("busy_after_cfg_err", busy, 0);
            @(posedge clk); #1;
        end
        check("cfg_err_pulses", 64'(ce_cnt - ce_s), 1);
        check("no_strobes_after_err", 64'((lt_cnt - lt_s) + (lf_cnt - lf_s) + (st_cnt - st_s)), 0);

        run_job(1'b0, 0,  1'b0, 1'b0, 1'b0, 0);
        run_job(1'b1, 0,  1'b1, 1'b0, 1'b0, 0);
        run_job(1'b0, 20, 1'b1, 1'b1, 1'b0, 0);
        run_job(1'b0, 4,  1'b1, 1'b0, 1'b0, 20);
        run_job(1'b0, 16, 1'b1, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
